// File: rtl/afifo_arb_pkg.sv
// Shared types and the round-robin search used by the async FIFO write-port arbiter.
package afifo_arb_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Index of the first set bit of mask at or after start (wrapping at n), or -1 when mask is empty.
  function automatic int rr_next(input logic [MAX_REQ-1:0] mask, input int start, input int n);
    int r;
    int k;
    r = -1;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        k = (start + i) % n;
        if (mask[k[3:0]]) r = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/afifo_rr_picker.sv
// Combinational round-robin picker: first requester in req_mask at or after start, with wrap.
module afifo_rr_picker
  import afifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic [IDW-1:0]     start,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  always_comb begin
    int p;
    p     = rr_next(MAX_REQ'(req_mask), int'(start), NUM_REQ);
    found = (p >= 0);
    idx   = IDW'(p);
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing the async FIFO write port among NUM_REQ producers.
module afifo_wr_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

  arb_state_t            state;
  logic [IDW-1:0]        last_id;
  logic [BCW-1:0]        burst_cnt;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  logic                  in_grant;
  logic                  owner_valid;
  logic                  accept;
  logic                  burst_last;
  logic                  tenure_end;
  logic [NUM_REQ-1:0]    owner_mask;
  logic [NUM_REQ-1:0]    pick_mask;
  logic [IDW-1:0]        pick_start;
  logic                  pick_found;
  logic [IDW-1:0]        pick_idx;

  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign in_grant    = (state == GRANT);
  assign owner_valid = req_valid[grant_id];
  assign owner_mask  = NUM_REQ'(1) << grant_id;
  // wfull gates the strobe in the same cycle, so a full FIFO is never written.
  assign accept      = in_grant & arb_en & owner_valid & ~wfull;
  assign burst_last  = (burst_cnt == BCW'(MAX_BURST - 1));
  assign tenure_end  = in_grant & ((accept & burst_last) | ~owner_valid | ~arb_en);

  // While granted the owner is excluded, so a hit means another producer is waiting.
  assign pick_mask  = in_grant ? (req_valid & ~owner_mask) : req_valid;
  assign pick_start = inc_wrap(in_grant ? grant_id : last_id);

  afifo_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req_mask (pick_mask),
    .start    (pick_start),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    winc      = accept;
    req_ready = accept ? owner_mask : '0;
    wdata     = in_grant ? words[grant_id] : '0;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      grant_vld <= 1'b0;
      grant_id  <= '0;
      burst_cnt <= '0;
      last_id   <= LAST_IDX;
    end else begin
      case (state)
        IDLE: begin
          if (arb_en && pick_found) begin
            state     <= GRANT;
            grant_vld <= 1'b1;
            grant_id  <= pick_idx;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (tenure_end) begin
            last_id   <= grant_id;
            burst_cnt <= '0;
            if (arb_en && pick_found) begin
              grant_id <= pick_idx;
            end else if (!(arb_en && owner_valid)) begin
              state     <= IDLE;
              grant_vld <= 1'b0;
            end
          end else begin
            burst_cnt <= burst_cnt + BCW'(accept);
          end
        end
        default: begin
          state     <= IDLE;
          grant_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Bench for afifo_wr_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_afifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int IDW        = 2;

  logic                          wclk = 1'b0;
  logic                          wrst_n = 1'b0;
  logic                          arb_en = 1'b0;
  logic                          wfull = 1'b0;
  logic [NUM_REQ-1:0]            req_valid = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic                          grant_vld;
  logic [IDW-1:0]                grant_id;

  int n_tests = 0;
  int n_fail  = 0;
  int seq [NUM_REQ];
  int wr_log [$];

  bit m_busy;
  int m_owner, m_used, m_last;

  logic           obs_winc, obs_gvld;
  logic [IDW-1:0] obs_gid;

  afifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Each producer emits {id, sequence number} so lost or reordered words are visible in wdata.
  function automatic logic [DATA_WIDTH-1:0] word_of(input int i);
    return DATA_WIDTH'((i << 6) | (seq[i] & 63));
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int from);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(from + k) % NUM_REQ]) return (from + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_used  = 0;
    m_last  = NUM_REQ - 1;
  endtask

  // One clock cycle: present data, check outputs mid-cycle, advance the model, cross the edge.
  task automatic step();
    logic               acc;
    logic [NUM_REQ-1:0] others;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_WIDTH +: DATA_WIDTH] = word_of(i);
    #4;
    obs_winc = winc;
    obs_gvld = grant_vld;
    obs_gid  = grant_id;
    if (!wrst_n) begin
      chk("rst_winc", 32'(winc), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_gvld", 32'(grant_vld), 0);
      chk("rst_wdata", 32'(wdata), 0);
      model_reset();
    end else begin
      acc = m_busy && arb_en && req_valid[m_owner] && !wfull;
      chk("winc", 32'(winc), 32'(acc));
      chk("req_ready", 32'(req_ready), acc ? (32'd1 << m_owner) : 32'd0);
      chk("wdata", 32'(wdata), m_busy ? 32'(word_of(m_owner)) : 32'd0);
      chk("grant_vld", 32'(grant_vld), 32'(m_busy));
      chk("grant_id", 32'(grant_id), 32'(m_owner));
      if (acc) begin
        wr_log.push_back(m_owner);
        seq[m_owner]++;
      end
      if (!m_busy) begin
        if (arb_en && req_valid != '0) begin
          m_busy  = 1'b1;
          m_owner = rr_pick(req_valid, (m_last + 1) % NUM_REQ);
          m_used  = 0;
        end
      end else if ((acc && m_used + 1 == MAX_BURST) || !req_valid[m_owner] || !arb_en) begin
        others = req_valid & ~(NUM_REQ'(1) << m_owner);
        m_last = m_owner;
        m_used = 0;
        if (arb_en && others != '0) m_owner = rr_pick(others, (m_owner + 1) % NUM_REQ);
        else if (!(arb_en && req_valid[m_owner])) m_busy = 1'b0;
      end else if (acc) begin
        m_used++;
      end
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    step();
    wrst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;
    model_reset();
    @(posedge wclk);
    #1;

    // Reset held with everyone requesting, then fairness order after release
    arb_en    = 1'b1;
    req_valid = '1;
    repeat (3) step();
    wrst_n = 1'b1;
    wr_log.delete();
    step();
    chk("t1_idle_gvld", 32'(obs_gvld), 0);
    repeat (17) step();
    chk("t2_count", wr_log.size(), 17);
    for (int k = 0; k < 17; k++)
      chk("t2_order", (wr_log.size() > k) ? wr_log[k] : -1, (k / MAX_BURST) % NUM_REQ);

    // Backpressure with id1 two words into its burst
    do_reset();
    req_valid = 4'b0010;
    repeat (3) step();
    req_valid = '1;
    wfull     = 1'b1;
    repeat (5) begin
      step();
      chk("t3_bp_winc", 32'(obs_winc), 0);
      chk("t3_bp_gid", 32'(obs_gid), 1);
    end
    wfull = 1'b0;
    wr_log.delete();
    repeat (3) step();
    chk("t3_count", wr_log.size(), 3);
    for (int k = 0; k < 3; k++)
      chk("t3_order", (wr_log.size() > k) ? wr_log[k] : -1, (k < 2) ? 1 : 2);

    // Early drop: id2 writes once then leaves, id3 takes over without a bubble
    do_reset();
    req_valid = 4'b0100;
    repeat (2) step();
    req_valid = 4'b1000;
    step();
    chk("t4_drop_winc", 32'(obs_winc), 0);
    step();
    chk("t4_gid", 32'(obs_gid), 3);
    chk("t4_winc", 32'(obs_winc), 1);

    // Lone requester re-granted every burst without gaps
    do_reset();
    req_valid = 4'b0001;
    step();
    wr_log.delete();
    repeat (10) step();
    chk("t5_count", wr_log.size(), 10);
    for (int k = 0; k < 10; k++)
      chk("t5_owner", (wr_log.size() > k) ? wr_log[k] : -1, 0);

    // arb_en dropped mid-burst, then async reset mid-burst
    do_reset();
    req_valid = '1;
    repeat (3) step();
    arb_en = 1'b0;
    step();
    chk("t6_dis_winc", 32'(obs_winc), 0);
    step();
    chk("t6_dis_idle", 32'(obs_gvld), 0);
    arb_en = 1'b1;
    repeat (2) step();
    chk("t6_regrant_gid", 32'(obs_gid), 1);
    step();
    #3;
    wrst_n = 1'b0;
    #1;
    chk("t6_arst_winc", 32'(winc), 0);
    chk("t6_arst_gvld", 32'(grant_vld), 0);
    chk("t6_arst_ready", 32'(req_ready), 0);
    model_reset();
    @(posedge wclk);
    #1;
    step();
    wrst_n = 1'b1;
    repeat (2) step();
    chk("t6_after_rst_gid", 32'(obs_gid), 0);
    chk("t6_after_rst_gvld", 32'(obs_gvld), 1);

    // Randomized traffic with sticky valids, backpressure, disables and occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 3) == 0) req_valid[i] = ~req_valid[i];
      wfull  = ($urandom_range(0, 9) < 3);
      arb_en = ($urandom_range(0, 19) != 0);
      wrst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
